// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared constants, types and helpers for the 5-port mesh
//                router output stage. Bit order of all 5-bit direction
//                vectors is L,R,U,D,PE = [4:0]; index order is 0=L .. 4=PE,
//                so index i lives in bit (4-i).
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int FLIT_WIDTH = 64;
    localparam int NUM_PORTS  = 5;

    // One-hot direction codes in request/buf_clear bit order.
    localparam logic [4:0] DIR_L  = 5'b10000;
    localparam logic [4:0] DIR_R  = 5'b01000;
    localparam logic [4:0] DIR_U  = 5'b00100;
    localparam logic [4:0] DIR_D  = 5'b00010;
    localparam logic [4:0] DIR_PE = 5'b00001;

    // Round-robin index of each direction.
    localparam logic [2:0] IDX_L  = 3'd0;
    localparam logic [2:0] IDX_R  = 3'd1;
    localparam logic [2:0] IDX_U  = 3'd2;
    localparam logic [2:0] IDX_D  = 3'd3;
    localparam logic [2:0] IDX_PE = 3'd4;

    // Output staging register occupancy.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // (base + off) mod 5 for base, off in 0..4.
    function automatic logic [2:0] wrap_idx(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 4'd5) begin
            sum = sum - 4'd5;
        end
        return sum[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : 5-way round-robin arbiter. Searches the request vector in
//                index order starting at the registered pointer, wrapping
//                4->0, and returns a one-hot grant. The pointer moves to the
//                index after the winner when 'advance' is strobed.
//  Ports       : clk, rst (async, active-high)
//                req[4:0]   requests, bit order L,R,U,D,PE = [4:0]
//                advance    commit the current grant and rotate priority
//                grant[4:0] one-hot winner, same bit order as req
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import router_pkg::*;
#(
    parameter int RR_INIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req,
    input  logic       advance,
    output logic [4:0] grant
);

    localparam logic [2:0] c_rr_init = 3'(RR_INIT);

    logic [2:0] r_ptr;
    logic [4:0] w_req_idx;
    logic [4:0] w_grant_idx;
    logic [2:0] w_win;
    logic       w_found;

    // Convert between bit order (L at MSB) and index order (L at index 0).
    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_bit_map
            assign w_req_idx[i]  = req[4-i];
            assign grant[4-i]    = w_grant_idx[i];
        end
    endgenerate

    always_comb begin
        w_found     = 1'b0;
        w_win       = 3'd0;
        w_grant_idx = '0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            if (!w_found && w_req_idx[wrap_idx(r_ptr, 3'(off))]) begin
                w_found = 1'b1;
                w_win   = wrap_idx(r_ptr, 3'(off));
            end
        end
        if (w_found) begin
            w_grant_idx[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= c_rr_init;
        end else if (advance && w_found) begin
            r_ptr <= (w_win == IDX_PE) ? IDX_L : (w_win + 3'd1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/output_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : output_arbiter
//  Description : Per-output-port arbiter and one-entry staging register of
//                the mesh router. Round-robin grants one of the five input
//                requests (U-turn masked), captures its flit, pulses the
//                winner's buf_clear and presents the flit downstream with a
//                so/ro handshake. A drain and a new grant may share an edge,
//                giving one flit per cycle.
//  Ports       : clk, rst (async, active-high)
//                req[4:0]                       requests, L,R,U,D,PE = [4:0]
//                data_l/r/u/d/pe[DATA_WIDTH-1:0] flits of the five inputs
//                ro                             downstream ready
//                so                             flit valid downstream
//                datao[DATA_WIDTH-1:0]          staged flit
//                buf_clear[4:0]                 one-hot grant pulse
//                grant_cnt[15:0], stall_cnt[15:0]  only with ARB_STATS_EN
//  Options     : `define ARB_STATS_EN adds grant (wrapping) and stall
//                (saturating) counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_arbiter
    import router_pkg::*;
#(
    parameter int         DATA_WIDTH = FLIT_WIDTH,
    parameter logic [4:0] DIRECTION  = DIR_L,
    parameter int         RR_INIT    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            req,
    input  logic [DATA_WIDTH-1:0] data_l,
    input  logic [DATA_WIDTH-1:0] data_r,
    input  logic [DATA_WIDTH-1:0] data_u,
    input  logic [DATA_WIDTH-1:0] data_d,
    input  logic [DATA_WIDTH-1:0] data_pe,
    input  logic                  ro,
    output logic                  so,
    output logic [DATA_WIDTH-1:0] datao,
    output logic [4:0]            buf_clear
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]           grant_cnt,
    output logic [15:0]           stall_cnt
`endif
);

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic [4:0]            w_eff;
    logic [4:0]            w_grant;
    logic                  w_xfer;
    logic                  w_space;
    logic                  w_take;

    assign w_eff   = req & ~DIRECTION;
    assign w_xfer  = (r_state == FULL) && ro;
    // Register is free either because it is empty or because it drains now.
    assign w_space = (r_state == EMPTY) || w_xfer;
    assign w_take  = w_space && (|w_eff);

    rr_arbiter #(
        .RR_INIT (RR_INIT)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (w_eff),
        .advance (w_take),
        .grant   (w_grant)
    );

    assign buf_clear = w_take ? w_grant : 5'b00000;

    // Grant is one-hot, so an AND-OR mux selects the winner's flit.
    assign w_win_data = ({DATA_WIDTH{w_grant[4]}} & data_l)
                      | ({DATA_WIDTH{w_grant[3]}} & data_r)
                      | ({DATA_WIDTH{w_grant[2]}} & data_u)
                      | ({DATA_WIDTH{w_grant[1]}} & data_d)
                      | ({DATA_WIDTH{w_grant[0]}} & data_pe);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_take) begin
            w_state_next = FULL;
        end else if (w_xfer) begin
            w_state_next = EMPTY;
        end
    end

    // On a drain without refill the old flit stays in place; so qualifies it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (w_take) begin
            r_data <= w_win_data;
        end
    end

    assign so    = (r_state == FULL);
    assign datao = r_data;

`ifdef ARB_STATS_EN
    logic [15:0] r_grant_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_cnt <= 16'h0000;
            r_stall_cnt <= 16'h0000;
        end else begin
            if (w_take) begin
                r_grant_cnt <= r_grant_cnt + 16'h0001;
            end
            if (so && !ro && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'h0001;
            end
        end
    end

    assign grant_cnt = r_grant_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_output_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_arbiter
//  Description : Directed self-checking bench for output_arbiter with
//                DIRECTION=L (10000) and RR_INIT=0. Counter scenarios are
//                compiled only when ARB_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_output_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req;
    logic        ro;
    logic        so;
    logic [63:0] datao;
    logic [4:0]  buf_clear;
    logic [63:0] flit [5];
    logic [63:0] data_l, data_r, data_u, data_d, data_pe;
`ifdef ARB_STATS_EN
    logic [15:0] grant_cnt;
    logic [15:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    assign data_l  = flit[0];
    assign data_r  = flit[1];
    assign data_u  = flit[2];
    assign data_d  = flit[3];
    assign data_pe = flit[4];

    always #5 clk = ~clk;

    output_arbiter #(
        .DATA_WIDTH (64),
        .DIRECTION  (5'b10000),
        .RR_INIT    (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_l    (data_l),
        .data_r    (data_r),
        .data_u    (data_u),
        .data_d    (data_d),
        .data_pe   (data_pe),
        .ro        (ro),
        .so        (so),
        .datao     (datao),
        .buf_clear (buf_clear)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic test_reset();
        rst = 1'b1;
        req = 5'b00000;
        ro  = 1'b0;
        for (int i = 0; i < 5; i++) flit[i] = 64'h0;
        #2;
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL reset_so: got %b expected 0", so); end
        checks++; if (datao !== 64'h0) begin errors++; $display("FAIL reset_datao: got %h expected 0", datao); end
        checks++; if (buf_clear !== 5'b00000) begin errors++; $display("FAIL reset_buf_clear: got %b expected 00000", buf_clear); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_pe();
        @(negedge clk);
        req = 5'b00001; flit[4] = 64'hA5; ro = 1'b1;
        #1;
        checks++; if (buf_clear !== 5'b00001) begin errors++; $display("FAIL pe_buf_clear: got %b expected 00001", buf_clear); end
        @(posedge clk); #1;
        checks++; if (so !== 1'b1) begin errors++; $display("FAIL pe_so: got %b expected 1", so); end
        checks++; if (datao !== 64'hA5) begin errors++; $display("FAIL pe_datao: got %h expected a5", datao); end
        req = 5'b00000;
        #1;
        checks++; if (buf_clear !== 5'b00000) begin errors++; $display("FAIL pe_no_regrant: got %b expected 00000", buf_clear); end
        @(posedge clk); #1;
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL pe_drained_so: got %b expected 0", so); end
    endtask

    // Pointer is 0 here; L is masked so the order is R,U,D,PE repeating.
    task automatic test_round_robin();
        int          w;
        logic [4:0]  exp_bc;
        logic [63:0] exp_d;
        for (int i = 0; i < 5; i++) flit[i] = 64'(i + 1) << 12;
        @(negedge clk);
        req = 5'b11111; ro = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w      = 1 + (k % 4);
            exp_bc = 5'(5'b10000 >> w);
            exp_d  = flit[w];
            #1;
            checks++; if (buf_clear !== exp_bc) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, buf_clear, exp_bc); end
            @(posedge clk); #1;
            checks++; if (so !== 1'b1) begin errors++; $display("FAIL rr_so[%0d]: got %b expected 1", k, so); end
            checks++; if (datao !== exp_d) begin errors++; $display("FAIL rr_datao[%0d]: got %h expected %h", k, datao, exp_d); end
            flit[w] = flit[w] + 64'h1;
            @(negedge clk);
        end
        req = 5'b00000;
        @(posedge clk); #1;
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL rr_drain_so: got %b expected 0", so); end
    endtask

    // Pointer is 0; R is granted, then held for 5 stalled cycles.
    task automatic test_stall();
        @(negedge clk);
        ro = 1'b0; req = 5'b01000; flit[1] = 64'hB1;
        #1;
        checks++; if (buf_clear !== 5'b01000) begin errors++; $display("FAIL stall_first_grant: got %b expected 01000", buf_clear); end
        @(posedge clk); #1;
        flit[1] = 64'hB2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            checks++; if (buf_clear !== 5'b00000) begin errors++; $display("FAIL stall_buf_clear[%0d]: got %b expected 00000", k, buf_clear); end
            checks++; if (so !== 1'b1) begin errors++; $display("FAIL stall_so[%0d]: got %b expected 1", k, so); end
            checks++; if (datao !== 64'hB1) begin errors++; $display("FAIL stall_datao[%0d]: got %h expected b1", k, datao); end
            @(posedge clk);
        end
        @(negedge clk);
        ro = 1'b1;
        #1;
        checks++; if (buf_clear !== 5'b01000) begin errors++; $display("FAIL stall_release_grant: got %b expected 01000", buf_clear); end
        @(posedge clk); #1;
        checks++; if (datao !== 64'hB2) begin errors++; $display("FAIL stall_release_datao: got %h expected b2", datao); end
        checks++; if (so !== 1'b1) begin errors++; $display("FAIL stall_release_so: got %b expected 1", so); end
        req = 5'b00000;
        @(posedge clk); #1;
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL stall_drain_so: got %b expected 0", so); end
    endtask

    // Pointer is 2; D wins twice with no bubble between the flits.
    task automatic test_back_to_back();
        @(negedge clk);
        req = 5'b00010; ro = 1'b1; flit[3] = 64'hD1;
        #1;
        checks++; if (buf_clear !== 5'b00010) begin errors++; $display("FAIL b2b_grant1: got %b expected 00010", buf_clear); end
        @(posedge clk); #1;
        checks++; if (datao !== 64'hD1) begin errors++; $display("FAIL b2b_datao1: got %h expected d1", datao); end
        flit[3] = 64'hD2;
        @(negedge clk); #1;
        checks++; if (buf_clear !== 5'b00010) begin errors++; $display("FAIL b2b_grant2: got %b expected 00010", buf_clear); end
        checks++; if (so !== 1'b1) begin errors++; $display("FAIL b2b_so_full: got %b expected 1", so); end
        @(posedge clk); #1;
        checks++; if (so !== 1'b1) begin errors++; $display("FAIL b2b_so_nogap: got %b expected 1", so); end
        checks++; if (datao !== 64'hD2) begin errors++; $display("FAIL b2b_datao2: got %h expected d2", datao); end
        req = 5'b00000;
        @(posedge clk); #1;
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL b2b_drain_so: got %b expected 0", so); end
    endtask

    // Pointer is 4; after granting U it would be 3 (D first). Reset must
    // return it to 0 so that R wins the next all-request round.
    task automatic test_async_reset();
        @(negedge clk);
        req = 5'b00100; ro = 1'b1; flit[2] = 64'hC1;
        #1;
        checks++; if (buf_clear !== 5'b00100) begin errors++; $display("FAIL arst_grant: got %b expected 00100", buf_clear); end
        @(posedge clk); #1;
        checks++; if (datao !== 64'hC1) begin errors++; $display("FAIL arst_datao_full: got %h expected c1", datao); end
        req = 5'b00000; ro = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL arst_so: got %b expected 0", so); end
        checks++; if (datao !== 64'h0) begin errors++; $display("FAIL arst_datao: got %h expected 0", datao); end
        @(negedge clk);
        rst = 1'b0; req = 5'b11111; ro = 1'b1; flit[1] = 64'hE1;
        #1;
        checks++; if (buf_clear !== 5'b01000) begin errors++; $display("FAIL arst_ptr_grant: got %b expected 01000", buf_clear); end
        @(posedge clk); #1;
        req = 5'b00000;
        checks++; if (datao !== 64'hE1) begin errors++; $display("FAIL arst_ptr_datao: got %h expected e1", datao); end
        @(posedge clk); #1;
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL arst_drain_so: got %b expected 0", so); end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        rst = 1'b1; req = 5'b00000; ro = 1'b1;
        #1;
        rst = 1'b0;
        checks++; if (grant_cnt !== 16'h0) begin errors++; $display("FAIL stats_reset_grant: got %h expected 0", grant_cnt); end
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL stats_reset_stall: got %h expected 0", stall_cnt); end
        @(negedge clk);
        req = 5'b00001; flit[4] = 64'hF1;
        repeat (3) @(posedge clk);
        #1;
        req = 5'b00000; ro = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (grant_cnt !== 16'd3) begin errors++; $display("FAIL stats_grant_cnt: got %0d expected 3", grant_cnt); end
        checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL stats_stall_cnt: got %0d expected 4", stall_cnt); end
        ro = 1'b1;
        @(posedge clk);
        @(negedge clk);
        force dut.r_grant_cnt = 16'hFFFE;
        force dut.r_stall_cnt = 16'hFFFE;
        #1;
        release dut.r_grant_cnt;
        release dut.r_stall_cnt;
        req = 5'b00001; ro = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req = 5'b00000; ro = 1'b0;
        checks++; if (grant_cnt !== 16'h0000) begin errors++; $display("FAIL stats_grant_wrap: got %h expected 0000", grant_cnt); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stats_stall_sat: got %h expected ffff", stall_cnt); end
        checks++; if (grant_cnt !== 16'h0000) begin errors++; $display("FAIL stats_grant_hold: got %h expected 0000", grant_cnt); end
        ro = 1'b1;
        @(posedge clk);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_pe();
        test_round_robin();
        test_stall();
        test_back_to_back();
        test_async_reset();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
